// File: rtl/conv2_window_buffer.sv
// Sliding 5x5 window generator for conv layer 2: six channels of a 12x12 raster
// stream in, one complete KERNEL x KERNEL window per channel out per accepted beat.
module conv2_window_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int MAP_WIDTH  = 12,
   parameter int KERNEL     = 5
) (
   input  logic                                 Clock,
   input  logic                                 Input_Reset,
   input  logic                                 Input_Valid,
   input  logic                                 Input_Finish,
   input  logic [DATA_WIDTH-1:0]                Input_Pixel_1,
   input  logic [DATA_WIDTH-1:0]                Input_Pixel_2,
   input  logic [DATA_WIDTH-1:0]                Input_Pixel_3,
   input  logic [DATA_WIDTH-1:0]                Input_Pixel_4,
   input  logic [DATA_WIDTH-1:0]                Input_Pixel_5,
   input  logic [DATA_WIDTH-1:0]                Input_Pixel_6,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Output_Window_1,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Output_Window_2,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Output_Window_3,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Output_Window_4,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Output_Window_5,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  Output_Window_6,
   output logic                                 Output_Valid,
   output logic                                 Output_Finish
);

   localparam int CHANNELS = 6;
   localparam int WIN_W    = KERNEL * KERNEL * DATA_WIDTH;
   localparam int LB_ROWS  = KERNEL - 1;
   localparam int CW       = $clog2(MAP_WIDTH);
   localparam int SW       = (LB_ROWS > 1) ? $clog2(LB_ROWS) : 1;
   localparam logic [CW-1:0] POS_LAST      = CW'(MAP_WIDTH - 1);
   localparam logic [CW-1:0] POS_FIRST_WIN = CW'(KERNEL - 1);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [CW-1:0]         col_reg;
   logic [CW-1:0]         row_reg;
   logic [0:0]            state_reg;
   logic                  last_col;
   logic                  last_row;
   logic                  emit;
   logic                  abort;
   logic [SW-1:0]         slot [LB_ROWS];
   logic [DATA_WIDTH-1:0] pix [CHANNELS];
   logic [WIN_W-1:0]      win_out [CHANNELS];

   assign pix[0] = Input_Pixel_1;
   assign pix[1] = Input_Pixel_2;
   assign pix[2] = Input_Pixel_3;
   assign pix[3] = Input_Pixel_4;
   assign pix[4] = Input_Pixel_5;
   assign pix[5] = Input_Pixel_6;

   assign Output_Window_1 = win_out[0];
   assign Output_Window_2 = win_out[1];
   assign Output_Window_3 = win_out[2];
   assign Output_Window_4 = win_out[3];
   assign Output_Window_5 = win_out[4];
   assign Output_Window_6 = win_out[5];

   assign last_col = (col_reg == POS_LAST);
   assign last_row = (row_reg == POS_LAST);
   assign emit     = Input_Valid && (row_reg >= POS_FIRST_WIN) && (col_reg >= POS_FIRST_WIN);
   assign abort    = !Input_Valid && Input_Finish && (state_reg == ST_ACTIVE);

   // Line-buffer slot holding row (row-LB_ROWS+gi); slot[0] is also where the current row lands.
   genvar gi;
   generate
      for (gi = 0; gi < LB_ROWS; gi++) begin : g_slot
         assign slot[gi] = SW'((int'(row_reg) + gi) % LB_ROWS);
      end
   endgenerate

   always_ff @(posedge Clock or posedge Input_Reset) begin
      if (Input_Reset) begin
         col_reg   <= '0;
         row_reg   <= '0;
         state_reg <= ST_IDLE;
      end else if (Input_Valid) begin
         col_reg <= last_col ? '0 : col_reg + 1'b1;
         if (last_col) begin
            row_reg <= last_row ? '0 : row_reg + 1'b1;
         end
         state_reg <= (last_col && last_row) ? ST_IDLE : ST_ACTIVE;
      end else if (abort) begin
         col_reg   <= '0;
         row_reg   <= '0;
         state_reg <= ST_IDLE;
      end
   end

   always_ff @(posedge Clock or posedge Input_Reset) begin
      if (Input_Reset) begin
         Output_Valid  <= 1'b0;
         Output_Finish <= 1'b0;
      end else begin
         Output_Valid  <= emit;
         Output_Finish <= Input_Valid && last_col && last_row;
      end
   end

   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] lb_mem [LB_ROWS][MAP_WIDTH];
         logic [WIN_W-1:0]      win_reg;
         logic [WIN_W-1:0]      win_next;
         logic [WIN_W-1:0]      out_reg;

         // Shift every row one column left; the right column comes from the line buffers plus the live pixel.
         always_comb begin
            win_next = win_reg;
            for (int r = 0; r < KERNEL; r++) begin
               for (int c = 0; c < KERNEL - 1; c++) begin
                  win_next[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] =
                     win_reg[(r*KERNEL+c+1)*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            for (int r = 0; r < KERNEL - 1; r++) begin
               win_next[(r*KERNEL+KERNEL-1)*DATA_WIDTH +: DATA_WIDTH] = lb_mem[slot[r]][col_reg];
            end
            win_next[(KERNEL*KERNEL-1)*DATA_WIDTH +: DATA_WIDTH] = pix[gi];
         end

         always_ff @(posedge Clock) begin
            if (Input_Valid) begin
               lb_mem[slot[0]][col_reg] <= pix[gi];
            end
         end

         always_ff @(posedge Clock or posedge Input_Reset) begin
            if (Input_Reset) begin
               win_reg <= '0;
               out_reg <= '0;
            end else if (Input_Valid) begin
               win_reg <= win_next;
               if (emit) begin
                  out_reg <= win_next;
               end
            end
         end

         assign win_out[gi] = out_reg;
      end
   endgenerate

endmodule

// File: tb/tb_conv2_window_buffer.sv
// Bench for conv2_window_buffer: an image-based reference model predicts every
// output cycle; directed frames pin counts and corner elements with literals.
module tb_conv2_window_buffer;

   localparam int DW = 32;
   localparam int MW = 12;
   localparam int K  = 5;
   localparam int WW = K * K * DW;

   logic          Clock = 1'b0;
   logic          Input_Reset = 1'b1;
   logic          Input_Valid = 1'b0;
   logic          Input_Finish = 1'b0;
   logic [DW-1:0] pix_in [6];
   logic [WW-1:0] dut_win [6];
   logic          Output_Valid;
   logic          Output_Finish;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   conv2_window_buffer #(.DATA_WIDTH(DW), .MAP_WIDTH(MW), .KERNEL(K)) dut (
      .Clock(Clock),
      .Input_Reset(Input_Reset),
      .Input_Valid(Input_Valid),
      .Input_Finish(Input_Finish),
      .Input_Pixel_1(pix_in[0]),
      .Input_Pixel_2(pix_in[1]),
      .Input_Pixel_3(pix_in[2]),
      .Input_Pixel_4(pix_in[3]),
      .Input_Pixel_5(pix_in[4]),
      .Input_Pixel_6(pix_in[5]),
      .Output_Window_1(dut_win[0]),
      .Output_Window_2(dut_win[1]),
      .Output_Window_3(dut_win[2]),
      .Output_Window_4(dut_win[3]),
      .Output_Window_5(dut_win[4]),
      .Output_Window_6(dut_win[5]),
      .Output_Valid(Output_Valid),
      .Output_Finish(Output_Finish)
   );

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got %0h want %0h", name, act, want);
      end
   endtask

   // Reference model: the current frame as a 2-D image; a window is a 5x5 crop ending at the new pixel.
   logic [DW-1:0] img [6][MW][MW];
   int            mrow = 0;
   int            mcol = 0;
   bit            mactive = 1'b0;
   logic          exp_valid = 1'b0;
   logic          exp_finish = 1'b0;
   logic [WW-1:0] exp_win [6];

   always @(posedge Clock or posedge Input_Reset) begin
      if (Input_Reset) begin
         mrow = 0; mcol = 0; mactive = 1'b0;
         exp_valid = 1'b0; exp_finish = 1'b0;
         for (int k = 0; k < 6; k++) exp_win[k] = '0;
      end else begin
         exp_valid = 1'b0;
         exp_finish = 1'b0;
         if (Input_Valid) begin
            for (int k = 0; k < 6; k++) img[k][mrow][mcol] = pix_in[k];
            if (mrow >= K - 1 && mcol >= K - 1) begin
               exp_valid = 1'b1;
               for (int k = 0; k < 6; k++)
                  for (int r = 0; r < K; r++)
                     for (int c = 0; c < K; c++)
                        exp_win[k][(r*K+c)*DW +: DW] = img[k][mrow-K+1+r][mcol-K+1+c];
            end
            exp_finish = (mrow == MW - 1 && mcol == MW - 1);
            if (mcol == MW - 1) begin
               mcol = 0;
               mrow = (mrow == MW - 1) ? 0 : mrow + 1;
            end else begin
               mcol = mcol + 1;
            end
            mactive = !(mrow == 0 && mcol == 0);
         end else if (Input_Finish && mactive) begin
            mrow = 0; mcol = 0; mactive = 1'b0;
         end
      end
   end

   // Compare process plus a log of corner elements of every emitted window.
   int            win_cnt = 0;
   int            fin_cnt = 0;
   logic [DW-1:0] el00 [1024][6];
   logic [DW-1:0] el44 [1024][6];

   always @(negedge Clock) begin
      chk("valid", WW'(Output_Valid), WW'(exp_valid));
      chk("finish", WW'(Output_Finish), WW'(exp_finish));
      for (int k = 0; k < 6; k++) chk($sformatf("win%0d", k + 1), dut_win[k], exp_win[k]);
      if (Output_Valid === 1'b1) begin
         if (win_cnt < 1024) begin
            for (int k = 0; k < 6; k++) begin
               el00[win_cnt][k] = dut_win[k][0 +: DW];
               el44[win_cnt][k] = dut_win[k][(K*K-1)*DW +: DW];
            end
         end
         win_cnt++;
      end
      if (Output_Finish === 1'b1) fin_cnt++;
   end

   task automatic beat(input bit v, input bit f, input int idx, input int offset, input bit rnd);
      @(negedge Clock);
      Input_Valid  = v;
      Input_Finish = f;
      for (int k = 0; k < 6; k++)
         pix_in[k] = rnd ? DW'($urandom) : DW'(((k + 1) << 16) | (offset + idx));
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   task automatic frame(input int offset, input bit bubbles);
      for (int i = 0; i < MW * MW; i++) begin
         beat(1'b1, 1'b0, i, offset, 1'b0);
         if (bubbles) beat(1'b0, 1'b0, 0, 0, 1'b1);
      end
   endtask

   task automatic chk_frame(input string name, input int wb, input int offset);
      if (wb + 63 < 1024) begin
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_first00_ch%0d", name, k + 1), WW'(el00[wb][k]), WW'(((k + 1) << 16) | offset));
            chk($sformatf("%s_first44_ch%0d", name, k + 1), WW'(el44[wb][k]), WW'(((k + 1) << 16) | (offset + 52)));
            chk($sformatf("%s_last44_ch%0d", name, k + 1), WW'(el44[wb+63][k]), WW'(((k + 1) << 16) | (offset + 143)));
         end
      end
   endtask

   int wb;
   int fb;

   initial begin
      for (int k = 0; k < 6; k++) pix_in[k] = '0;
      repeat (3) @(negedge Clock);
      chk("reset_valid", WW'(Output_Valid), '0);
      chk("reset_finish", WW'(Output_Finish), '0);
      chk("reset_win1", dut_win[0], '0);
      chk("reset_win6", dut_win[5], '0);
      Input_Reset = 1'b0;

      // Ramp frame
      wb = win_cnt; fb = fin_cnt;
      frame(0, 1'b0);
      idle(3);
      chk("ramp_windows", WW'(win_cnt - wb), WW'(64));
      chk("ramp_finishes", WW'(fin_cnt - fb), WW'(1));
      chk_frame("ramp", wb, 0);

      // Bubbles between every beat
      wb = win_cnt; fb = fin_cnt;
      frame(0, 1'b1);
      idle(3);
      chk("bubble_windows", WW'(win_cnt - wb), WW'(64));
      chk("bubble_finishes", WW'(fin_cnt - fb), WW'(1));
      chk_frame("bubble", wb, 0);

      // Abort after 70 beats, Input_Finish held for two cycles
      fb = fin_cnt;
      for (int i = 0; i < 70; i++) beat(1'b1, 1'b0, i, 0, 1'b0);
      beat(1'b0, 1'b1, 0, 0, 1'b1);
      beat(1'b0, 1'b1, 0, 0, 1'b1);
      idle(2);
      chk("abort_finishes", WW'(fin_cnt - fb), WW'(0));
      wb = win_cnt; fb = fin_cnt;
      frame(32'h1000, 1'b0);
      idle(3);
      chk("after_abort_windows", WW'(win_cnt - wb), WW'(64));
      chk("after_abort_finishes", WW'(fin_cnt - fb), WW'(1));
      chk_frame("after_abort", wb, 32'h1000);

      // Back-to-back frames
      wb = win_cnt; fb = fin_cnt;
      frame(0, 1'b0);
      frame(32'h2000, 1'b0);
      idle(3);
      chk("b2b_windows", WW'(win_cnt - wb), WW'(128));
      chk("b2b_finishes", WW'(fin_cnt - fb), WW'(2));
      chk_frame("b2b_second", wb + 64, 32'h2000);

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i <= 60; i++) beat(1'b1, 1'b0, i, 32'h3000, 1'b0);
      @(posedge Clock);
      #2;
      Input_Reset = 1'b1;
      Input_Valid = 1'b0;
      #1;
      chk("midreset_valid", WW'(Output_Valid), '0);
      chk("midreset_finish", WW'(Output_Finish), '0);
      for (int k = 0; k < 6; k++) chk($sformatf("midreset_win%0d", k + 1), dut_win[k], '0);
      repeat (2) @(negedge Clock);
      Input_Reset = 1'b0;
      wb = win_cnt; fb = fin_cnt;
      frame(32'h4000, 1'b0);
      idle(3);
      chk("post_reset_windows", WW'(win_cnt - wb), WW'(64));
      chk("post_reset_finishes", WW'(fin_cnt - fb), WW'(1));
      chk_frame("post_reset", wb, 32'h4000);

      // Random data, random stalls, random Input_Finish (including alongside valid beats)
      repeat (1500) beat($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 0, 0, 1'b1);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conv2_window_buffer.md
# conv2_window_buffer

Sliding-window generator sitting directly downstream of the layer-1 sampling stage and upstream of convolution layer 2. It consumes the six-lane raster stream of 12x12 pooled feature maps, one pixel per lane per valid beat, and buffers four previous rows per channel. For every valid KERNELxKERNEL neighbourhood it presents the complete 5x5 window for all six channels in parallel, so conv layer 2 can compute one output position per cycle.

## Interface
- DATA_WIDTH, 32, bits per pixel; opaque, never interpreted arithmetically
- MAP_WIDTH, 12, feature-map width and height in pixels
- KERNEL, 5, window edge; windows per frame = (MAP_WIDTH-KERNEL+1)^2 = 64
- Clock  in  1  rising-edge clock
- Input_Reset  in  1  asynchronous, active-high reset
- Input_Valid  in  1  pixel beat on Input_Pixel_1..6 this cycle
- Input_Finish  in  1  upstream end-of-stream indication
- Input_Pixel_k (k=1..6)  in  DATA_WIDTH  channel-k pixel, raster order, row-major
- Output_Window_k (k=1..6)  out  KERNEL*KERNEL*DATA_WIDTH  channel-k window; element (r,c) at bits [(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH], r=0 top (oldest) row, c=0 leftmost column
- Output_Valid  out  1  Output_Window_1..6 hold a new window this cycle
- Output_Finish  out  1  one-cycle pulse with the last window of a frame

## Operation
- Counters col, row (0..MAP_WIDTH-1) give the raster position of the next accepted pixel; both reset to 0.
- States: IDLE (row=col=0, no frame in progress), ACTIVE (at least one pixel of the current frame accepted).
- Accept: any cycle with Input_Valid=1. Pixel written into per-channel line buffers (KERNEL-1 rows of MAP_WIDTH entries, circular by row) and into the per-channel KERNEL x KERNEL shift window (column shift left, new column = four buffered pixels of column col from rows row-4..row-1 plus the incoming pixel).
- col increments; at MAP_WIDTH-1 wraps to 0 and row increments; at (MAP_WIDTH-1, MAP_WIDTH-1) both wrap to 0, state -> IDLE.
- Window emitted for an accepted pixel iff row >= KERNEL-1 and col >= KERNEL-1; window covers rows row-4..row, cols col-4..col of the current frame only.
- Output_Finish asserted with the window of pixel (MAP_WIDTH-1, MAP_WIDTH-1).
- Stall: Input_Valid=0 -> no state change, Output_Valid=0, Output_Window_k hold last value.
- Abort: Input_Finish=1 with Input_Valid=0 while ACTIVE -> counters cleared, state -> IDLE, partial frame discarded, no Output_Finish. Input_Finish in IDLE, or held high, has no effect. Input_Valid=1 takes precedence over Input_Finish in the same cycle.
- Line-buffer contents are not reset. Rows of a previous or aborted frame never reach an emitted window because emission requires row >= KERNEL-1.

## Timing
- Reset (async, immediate): Output_Valid=0, Output_Finish=0, all Output_Window_k=0, counters=0, shift windows=0, state IDLE.
- Latency: Output_Valid/Output_Window_k/Output_Finish registered, one clock after the accepting edge.
- Throughput: one pixel per lane per clock, one window per clock, no backpressure; back-to-back frames with no gap are supported.
- First window of a frame follows input beat index 52 (row 4, col 4). Last window follows beat 143.
- Outputs are valid only in the Output_Valid cycle. Consumers must not sample them otherwise.

## Test plan
- Reset: assert Input_Reset mid-clock with no edge -> Output_Valid=0, Output_Finish=0, all windows 0 immediately.
- Ramp frame: channel k pixel (r,c) = (k<<16)|(r*12+c), 144 back-to-back beats -> exactly 64 Output_Valid cycles. First appears one cycle after beat 52 with element(0,0)=(k<<16)|0 and element(4,4)=(k<<16)|52. Last has element(4,4)=(k<<16)|143, with Output_Finish=1 in that cycle only.
- Bubbles: same frame with Input_Valid alternating 1/0 -> identical 64 windows in order, each one cycle after its accepting beat, and windows held during gaps.
- Abort: 70 beats, then Input_Finish=1 with Input_Valid=0 -> no Output_Finish. A following full ramp frame with offset 0x1000 -> 64 windows containing only new-frame values, with one Output_Finish.
- Back-to-back: two frames (288 beats, no gap) -> 128 windows and two Output_Finish pulses. The second frame's first window has element(0,0)=second-frame pixel (0,0).
- Reset mid-frame: async reset after beat 60, release, then a full frame -> outputs zero during reset, then exactly 64 correct windows and one finish pulse.
